// File: rtl/pst_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Package : pst_pkg                                                     |
// | Shared phase-coding constants, decoder state type and k helper.       |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package pst_pkg;

    localparam int         PHASE_W      = 8;
    localparam logic [7:0] PHASE_SILENT = 8'd255;
    localparam logic [7:0] CYCLE_LEN    = 8'd255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DIV  = 2'd2,
        ST_HOLD = 2'd3
    } dec_state_t;

    // Accumulation step count (1..256) that produces a spike at this phase.
    function automatic logic [8:0] phase_to_k(input logic [7:0] phase,
                                              input logic [7:0] offset);
        if (phase < offset)
            return 9'd1;
        else
            return {1'b0, phase - offset} + 9'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/phase_div_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : phase_div_seq                                               |
// | 9-bit restoring divider, start/done handshake, done 9 clocks after    |
// | start (first quotient bit is resolved on the start edge).             |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module phase_div_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic [8:0] i_num,
    input  logic [8:0] i_den,
    output logic       o_busy,
    output logic       o_done,
    output logic [7:0] o_quotient
);

    logic [8:0] r_rem;
    logic [8:0] r_quo;
    logic [8:0] r_den;
    logic [3:0] r_cnt;
    logic       r_busy;
    logic       r_done;

    logic [8:0] w_rem_in;
    logic [8:0] w_quo_in;
    logic [8:0] w_den_in;
    logic [9:0] w_trial;
    logic       w_ge;
    logic [8:0] w_rem_nxt;
    logic [8:0] w_quo_nxt;

    always_comb begin
        w_rem_in  = i_start ? 9'd0  : r_rem;
        w_quo_in  = i_start ? i_num : r_quo;
        w_den_in  = i_start ? i_den : r_den;
        w_trial   = {w_rem_in, w_quo_in[8]};
        w_ge      = (w_trial >= {1'b0, w_den_in});
        // The true difference is below den, so 9-bit wraparound is exact.
        w_rem_nxt = w_ge ? (w_trial[8:0] - w_den_in) : w_trial[8:0];
        w_quo_nxt = {w_quo_in[7:0], w_ge};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem  <= 9'd0;
            r_quo  <= 9'd0;
            r_den  <= 9'd0;
            r_cnt  <= 4'd0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_rem  <= w_rem_nxt;
                r_quo  <= w_quo_nxt;
                r_den  <= i_den;
                r_cnt  <= 4'd8;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_rem <= w_rem_nxt;
                r_quo <= w_quo_nxt;
                r_cnt <= r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_quotient = r_quo[7:0];

endmodule
`default_nettype wire

// File: rtl/phase_decoder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : phase_decoder                                               |
// | Captures first-spike phase per channel each gamma cycle, snapshots    |
// | the frame and streams ceil(THRESHOLD/k) per channel over valid/ready. |
// | Option  : SKIP_SILENT_EN - emit words for spiking channels only.      |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module phase_decoder
    import pst_pkg::*;
#(
    parameter int         N_CH         = 4,
    parameter logic [7:0] THRESHOLD    = 8'd64,
    parameter logic [7:0] PHASE_OFFSET = 8'd2,
    localparam int        CHW          = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PHASE_W-1:0]    global_phase,
    input  logic                  cycle_start,
    input  logic [N_CH-1:0]       spike_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CHW-1:0]        out_chan,
    output logic [PHASE_W-1:0]    out_phase,
    output logic [7:0]            out_intensity,
    output logic                  out_fired,
    output logic                  out_last,
    output logic                  overrun
);

    localparam logic [CHW-1:0] c_last_ch = CHW'(N_CH - 1);

    logic [N_CH-1:0]              r_cap_hit;
    logic [N_CH-1:0][PHASE_W-1:0] r_cap_phase;
    logic [N_CH-1:0]              r_shd_hit;
    logic [N_CH-1:0][PHASE_W-1:0] r_shd_phase;
    logic [N_CH-1:0]              w_snap_hit;
    logic [N_CH-1:0][PHASE_W-1:0] w_snap_phase;

    dec_state_t          r_state;
    logic [CHW-1:0]      r_ch;
    logic                r_out_valid;
    logic [CHW-1:0]      r_out_chan;
    logic [PHASE_W-1:0]  r_out_phase;
    logic [7:0]          r_out_intensity;
    logic                r_out_fired;
    logic                r_out_last;
    logic                r_overrun;

    logic [CHW-1:0]      w_sel_ch;
    logic                w_sel_valid;
    logic                w_sel_last;
    logic                w_sel_hit;
    logic [PHASE_W-1:0]  w_sel_phase;
    logic [8:0]          w_k;
    logic [8:0]          w_num;
    logic                w_div_start;
    logic                w_div_busy;
    logic                w_div_done;
    logic [7:0]          w_quot;

    always_ff @(posedge clk) begin
        if (rst || cycle_start) begin
            r_cap_hit   <= '0;
            r_cap_phase <= {N_CH{PHASE_SILENT}};
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (spike_in[i] && !r_cap_hit[i]) begin
                    r_cap_hit[i]   <= 1'b1;
                    r_cap_phase[i] <= global_phase;
                end
            end
        end
    end

    // A spike coincident with cycle_start still belongs to the ending frame.
    for (genvar i = 0; i < N_CH; i++) begin : g_snap
        assign w_snap_hit[i]   = r_cap_hit[i] | spike_in[i];
        assign w_snap_phase[i] = r_cap_hit[i] ? r_cap_phase[i] :
                                 (spike_in[i] ? global_phase : PHASE_SILENT);
    end

    always_comb begin
        w_sel_ch    = r_ch;
        w_sel_valid = 1'b1;
        w_sel_last  = (r_ch == c_last_ch);
`ifdef SKIP_SILENT_EN
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b1;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (i >= int'(r_ch) && r_shd_hit[i]) begin
                w_sel_ch    = CHW'(i);
                w_sel_valid = 1'b1;
            end
        end
        for (int i = 0; i < N_CH; i++) begin
            if (i > int'(w_sel_ch) && r_shd_hit[i])
                w_sel_last = 1'b0;
        end
`endif
    end

    assign w_sel_hit   = r_shd_hit[w_sel_ch];
    assign w_sel_phase = r_shd_phase[w_sel_ch];
    assign w_k         = phase_to_k(w_sel_phase, PHASE_OFFSET);
    assign w_num       = {1'b0, THRESHOLD} + w_k - 9'd1;
    assign w_div_start = (r_state == ST_LOAD) && w_sel_valid && w_sel_hit && !w_div_busy;

    phase_div_seq u_div (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_div_start),
        .i_num      (w_num),
        .i_den      (w_k),
        .o_busy     (w_div_busy),
        .o_done     (w_div_done),
        .o_quotient (w_quot)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_ch            <= '0;
            r_shd_hit       <= '0;
            r_shd_phase     <= {N_CH{PHASE_SILENT}};
            r_out_valid     <= 1'b0;
            r_out_chan      <= '0;
            r_out_phase     <= PHASE_SILENT;
            r_out_intensity <= 8'd0;
            r_out_fired     <= 1'b0;
            r_out_last      <= 1'b0;
            r_overrun       <= 1'b0;
        end else begin
            r_overrun <= cycle_start && (r_state != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (cycle_start) begin
                        r_shd_hit   <= w_snap_hit;
                        r_shd_phase <= w_snap_phase;
                        r_ch        <= '0;
                        r_state     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (!w_sel_valid) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_ch        <= w_sel_ch;
                        r_out_chan  <= w_sel_ch;
                        r_out_phase <= w_sel_phase;
                        r_out_fired <= w_sel_hit;
                        r_out_last  <= w_sel_last;
                        if (w_sel_hit) begin
                            r_state <= ST_DIV;
                        end else begin
                            r_out_intensity <= 8'd0;
                            r_out_valid     <= 1'b1;
                            r_state         <= ST_HOLD;
                        end
                    end
                end
                ST_DIV: begin
                    if (w_div_done) begin
                        r_out_intensity <= w_quot;
                        r_out_valid     <= 1'b1;
                        r_state         <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (r_out_last) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_ch    <= r_ch + 1'b1;
                            r_state <= ST_LOAD;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign out_valid     = r_out_valid;
    assign out_chan      = r_out_chan;
    assign out_phase     = r_out_phase;
    assign out_intensity = r_out_intensity;
    assign out_fired     = r_out_fired;
    assign out_last      = r_out_last;
    assign overrun       = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_phase_decoder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : tb_phase_decoder                                            |
// | Self-checking bench for phase_decoder (N_CH=4, THRESHOLD=64).         |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_phase_decoder;

    localparam int N  = 4;
    localparam int TH = 64;
    localparam int OF = 2;
`ifdef SKIP_SILENT_EN
    localparam int SK = 1;
`else
    localparam int SK = 0;
`endif

    typedef struct {
        int chan;
        int phase;
        int inten;
        int fired;
        int last;
    } word_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] global_phase;
    logic       cycle_start;
    logic [3:0] spike_in;
    logic       out_ready;
    logic       out_valid;
    logic [1:0] out_chan;
    logic [7:0] out_phase;
    logic [7:0] out_intensity;
    logic       out_fired;
    logic       out_last;
    logic       overrun;

    int    n_checks = 0;
    int    n_errors = 0;
    int    ovr_cnt  = 0;
    word_t exp_q[$];
    word_t log_q[$];
    int    m_ph[N];
    bit    m_hit[N];
    bit    m_ok     = 0;
    bit    m_after  = 0;
    int    m_ovr    = 0;

    phase_decoder #(.N_CH(N), .THRESHOLD(8'd64), .PHASE_OFFSET(8'd2)) dut (
        .clk           (clk),
        .rst           (rst),
        .global_phase  (global_phase),
        .cycle_start   (cycle_start),
        .spike_in      (spike_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_chan      (out_chan),
        .out_phase     (out_phase),
        .out_intensity (out_intensity),
        .out_fired     (out_fired),
        .out_last      (out_last),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Minimum current whose integration reaches the threshold in k steps.
    function automatic int model_int(input int ph);
        int k;
        k = (ph < OF) ? 1 : ph - OF + 1;
        return (TH / k) + (((TH % k) != 0) ? 1 : 0);
    endfunction

    task automatic push_frame();
        int last_hit;
        word_t w;
        last_hit = -1;
        for (int c = 0; c < N; c++)
            if (m_hit[c] || spike_in[c]) last_hit = c;
        for (int c = 0; c < N; c++) begin
            w.chan  = c;
            w.fired = (m_hit[c] || spike_in[c]) ? 1 : 0;
            w.phase = m_hit[c] ? m_ph[c] : (spike_in[c] ? int'(global_phase) : 255);
            w.inten = w.fired ? model_int(w.phase) : 0;
            w.last  = SK ? ((c == last_hit) ? 1 : 0) : ((c == N - 1) ? 1 : 0);
            if (!SK || w.fired) exp_q.push_back(w);
        end
    endtask

    // Compare process: checks registered outputs, then advances the model
    // over the edge that is about to sample the current inputs.
    initial begin
        forever begin
            bit busy;
            word_t w;
            @(negedge clk);
            if (m_ok) begin
                if (m_after) begin
                    chk("reset_valid", int'(out_valid), 0);
                    chk("reset_phase", int'(out_phase), 255);
                    m_after = 0;
                end
                chk("overrun", int'(overrun), m_ovr);
                if (overrun) ovr_cnt++;
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_word", 1, 0);
                    end else begin
                        chk("word_chan",  int'(out_chan),      exp_q[0].chan);
                        chk("word_phase", int'(out_phase),     exp_q[0].phase);
                        chk("word_inten", int'(out_intensity), exp_q[0].inten);
                        chk("word_fired", int'(out_fired),     exp_q[0].fired);
                        chk("word_last",  int'(out_last),      exp_q[0].last);
                    end
                end
            end
            if (rst) begin
                exp_q.delete();
                for (int c = 0; c < N; c++) begin
                    m_hit[c] = 0;
                    m_ph[c]  = 255;
                end
                m_ovr   = 0;
                m_after = 1;
                m_ok    = 1;
            end else if (m_ok) begin
                busy = (exp_q.size() != 0);
                if (out_valid && out_ready && exp_q.size() != 0) begin
                    w.chan  = int'(out_chan);
                    w.phase = int'(out_phase);
                    w.inten = int'(out_intensity);
                    w.fired = int'(out_fired);
                    w.last  = int'(out_last);
                    log_q.push_back(w);
                    void'(exp_q.pop_front());
                end
                m_ovr = 0;
                if (cycle_start) begin
                    if (busy) m_ovr = 1;
                    else push_frame();
                    for (int c = 0; c < N; c++) begin
                        m_hit[c] = 0;
                        m_ph[c]  = 255;
                    end
                end else begin
                    for (int c = 0; c < N; c++) begin
                        if (spike_in[c] && !m_hit[c]) begin
                            m_hit[c] = 1;
                            m_ph[c]  = int'(global_phase);
                        end
                    end
                end
            end
        end
    end

    task automatic step(input logic cs, input logic [7:0] ph, input logic [3:0] sp);
        cycle_start  = cs;
        global_phase = ph;
        spike_in     = sp;
        @(posedge clk);
        #1;
        cycle_start = 1'b0;
        spike_in    = 4'd0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 500) begin
            step(1'b0, 8'd0, 4'd0);
            n++;
        end
        if (n >= 500) chk("drain_timeout", n, 0);
    endtask

    function automatic int find_log(input int chan);
        for (int i = 0; i < log_q.size(); i++)
            if (log_q[i].chan == chan) return i;
        return -1;
    endfunction

    // Hand-computed word expectations, looked up by channel in the log.
    task automatic lit(input string name, input int chan, input int ph,
                       input int inten, input int fired, input int last);
        int i;
        i = find_log(chan);
        if (i < 0) begin
            chk({name, "_present"}, 0, 1);
        end else begin
            chk({name, "_phase"}, log_q[i].phase, ph);
            chk({name, "_inten"}, log_q[i].inten, inten);
            chk({name, "_fired"}, log_q[i].fired, fired);
            chk({name, "_last"},  log_q[i].last,  last);
        end
    endtask

    initial begin
        int lat;
        rst          = 1'b1;
        cycle_start  = 1'b0;
        global_phase = 8'd0;
        spike_in     = 4'd0;
        out_ready    = 1'b1;
        @(posedge clk); #1;
        step(1'b0, 8'd0, 4'd0);
        step(1'b0, 8'd0, 4'd0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_phase", int'(out_phase), 255);
        chk("rst_out_inten", int'(out_intensity), 0);
        chk("rst_out_last",  int'(out_last), 0);
        chk("rst_overrun",   int'(overrun), 0);
        rst = 1'b0;
        step(1'b0, 8'd0, 4'd0);

        // Basic frame: ch0@2, ch1@9, ch2@65, ch3 silent.
        log_q.delete();
        step(1'b0, 8'd2,  4'b0001);
        step(1'b0, 8'd9,  4'b0010);
        step(1'b0, 8'd65, 4'b0100);
        step(1'b1, 8'd70, 4'b0000);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        // LOAD is the first of 11 clocks; the word is up in the 11th.
        chk("hit_latency", lat, 10);
        wait_drain();
        lit("t1_ch0", 0, 2,  64, 1, 0);
        lit("t1_ch1", 1, 9,  8,  1, 0);
        lit("t1_ch2", 2, 65, 1,  1, SK);
`ifndef SKIP_SILENT_EN
        lit("t1_ch3", 3, 255, 0, 0, 1);
        chk("t1_words", log_q.size(), 4);
`endif

        // Below offset and large phase.
        log_q.delete();
        step(1'b0, 8'd1,   4'b0001);
        step(1'b0, 8'd200, 4'b0010);
        step(1'b1, 8'd5,   4'b0000);
        wait_drain();
        lit("t2_ch0", 0, 1,   64, 1, 0);
        lit("t2_ch1", 1, 200, 1,  1, SK);

        // Spike coincident with cycle_start at phase 255.
        log_q.delete();
        step(1'b1, 8'd255, 4'b0001);
        wait_drain();
        lit("t3_ch0", 0, 255, 1, 1, SK);
        log_q.delete();
        step(1'b1, 8'd3, 4'b0000);
        wait_drain();
`ifndef SKIP_SILENT_EN
        lit("t3_next_ch0", 0, 255, 0, 0, 0);
`else
        chk("t3_next_words", log_q.size(), 0);
`endif

        // Repeated spike: only the first phase counts.
        log_q.delete();
        step(1'b0, 8'd10, 4'b0010);
        step(1'b0, 8'd30, 4'b0010);
        step(1'b1, 8'd40, 4'b0000);
        wait_drain();
        lit("t4_ch1", 1, 10, 8, 1, SK);

        // Stalled consumer across a cycle boundary.
        log_q.delete();
        ovr_cnt   = 0;
        out_ready = 1'b0;
        step(1'b0, 8'd20, 4'b0001);
        step(1'b1, 8'd21, 4'b0000);
        step(1'b0, 8'd50, 4'b1000);
        step(1'b0, 8'd55, 4'b0000);
        step(1'b1, 8'd60, 4'b0000);
        step(1'b0, 8'd0,  4'b0000);
        step(1'b0, 8'd0,  4'b0000);
        out_ready = 1'b1;
        wait_drain();
        chk("t5_overrun_pulses", ovr_cnt, 1);
        lit("t5_ch0", 0, 20, 4, 1, SK);
`ifndef SKIP_SILENT_EN
        lit("t5_ch3", 3, 255, 0, 0, 1);
        chk("t5_words", log_q.size(), 4);
`else
        chk("t5_ch3_absent", find_log(3), -1);
`endif

        // Reset while the divider is running.
        step(1'b0, 8'd9, 4'b0001);
        step(1'b1, 8'd10, 4'b0000);
        step(1'b0, 8'd0, 4'b0000);
        step(1'b0, 8'd0, 4'b0000);
        step(1'b0, 8'd0, 4'b0000);
        rst = 1'b1;
        step(1'b0, 8'd0, 4'b0000);
        chk("t6_rst_valid", int'(out_valid), 0);
        chk("t6_rst_phase", int'(out_phase), 255);
        rst = 1'b0;
        log_q.delete();
        step(1'b0, 8'd0,  4'b0000);
        step(1'b0, 8'd9,  4'b0100);
        step(1'b1, 8'd12, 4'b0000);
        wait_drain();
        lit("t6_ch2", 2, 9, 8, 1, SK);
`ifdef SKIP_SILENT_EN
        chk("t6_words", log_q.size(), 1);
        chk("t6_chan", (log_q.size() > 0) ? log_q[0].chan : -1, 2);
`else
        chk("t6_words", log_q.size(), 4);
`endif

        chk("model_queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/phase_decoder.md
Name: phase_decoder

Overview:
Receive-side counterpart of the phase-coding neuron. It captures the gamma-cycle phase of the first spike on each of N_CH spike lines and, at each cycle boundary, snapshots the frame. It then decodes each captured phase back into the minimum input current consistent with that firing phase (ceil(THRESHOLD/k)). The decoded words are streamed out one channel at a time over a valid/ready interface, and the block sits downstream of the neuron array for readout and debug.

Parameters:
N_CH, 4, number of spike channels (1..16)
THRESHOLD, 8'd64, neuron firing threshold used for decode (1..255)
PHASE_OFFSET, 8'd2, global_phase value on which a spike from the first accumulation step arrives (includes neuron register latency)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
global_phase  in  8  phase from gamma oscillator
cycle_start  in  1  one-clock pulse marking a new gamma cycle
spike_in  in  N_CH  one-clock spike pulses, bit i = channel i
out_valid  out  1  output word valid
out_ready  in  1  consumer accepts word when out_valid&&out_ready
out_chan  out  max(1,$clog2(N_CH))  channel index of word
out_phase  out  8  captured raw phase (8'd255 if silent)
out_intensity  out  8  decoded intensity (0 if silent)
out_fired  out  1  channel spiked in the frame
out_last  out  1  last word of frame
overrun  out  1  one-clock pulse: frame dropped

Behaviour:
- One clock domain, clk. rst is synchronous and active-high.
- Reset clears all capture registers (phase=255, hit=0) and the shadow buffer. The FSM goes to IDLE. All outputs are 0 except out_phase=8'd255. Reset mid-stream abandons the frame without emitting out_last.
- Capture, per channel: the first spike_in[i] of a cycle latches global_phase and sets hit[i]. Later spikes in the same cycle are ignored.
- Capture clearing: on cycle_start, capture registers clear for the new cycle.
- Spike coincident with cycle_start: the spike belongs to the ending cycle. It is merged into the snapshot if the channel has not already hit.
- Snapshot: on cycle_start, if FSM is IDLE, copy capture (plus any coincident spikes) into the shadow buffer and go to LOAD with ch=0.
- Overrun: if the FSM is not IDLE on cycle_start, the new frame is discarded and overrun pulses for 1 clock. The current frame continues draining unaffected.
- FSM states: IDLE -> LOAD -> DIV -> HOLD -> (LOAD with ch+1 | IDLE).
  - LOAD, hit channel: k = (phase < PHASE_OFFSET) ? 1 : phase-PHASE_OFFSET+1, 9-bit range 1..256. Start the divider with num = THRESHOLD+k-1 (9-bit) and den = k. Go to DIV.
  - LOAD, silent channel: intensity=0. Go directly to HOLD (1 clock).
  - DIV: wait for divider done (exactly 9 clocks), latch quotient[7:0], then go to HOLD. Quotient is never >255, so no saturation is needed.
  - HOLD: out_valid=1. All out_* fields are stable until the handshake; out_last=1 when ch==N_CH-1.
  - HOLD exit: on out_valid&&out_ready, go to IDLE if last, else LOAD with ch+1. out_valid drops in the following cycle.
- Latency: hit word appears 11 clocks after LOAD entry; silent word appears 2 clocks after. Back-to-back accepted words do not stall beyond this.
- Frame budget: N_CH=16, all hit, ready held high is about 176 clocks, which is less than the 256-clock cycle, so no overrun occurs.

Optional Feature:
SKIP_SILENT_EN
- Defined: LOAD skips channels with hit=0, so silent channels produce no words. out_last marks the last emitted hit word. A frame with no hits emits nothing and the FSM returns to IDLE in 1 clock.
- Undefined: every channel is emitted, with out_fired=0 and intensity=0 for silent ones.

Decomposition:
- Shared package pst_pkg: PHASE_W=8, PHASE_SILENT=8'd255, CYCLE_LEN=8'd255, and the decoder FSM state enum typedef.
- One sub-module, phase_div_seq: 9-bit restoring divider with start/done handshake, fixed 9-cycle latency, busy flag. It is instantiated once and shared across channels.

Test Plan:
- N_CH=4, THRESHOLD=64. Spikes ch0@phase2, ch1@phase9, ch2@phase65, ch3 silent, then cycle_start. Required words: (0,2,64,1,0), (1,9,8,1,0), (2,65,1,1,0), (3,255,0,0,1).
- Spike ch0@phase1 (below offset) -> intensity 64. Spike ch1 at phase200 -> k=199 -> intensity 1.
- ch0 spike in the same clock as cycle_start at phase255 -> included in the ending frame, intensity 1, out_phase=255, fired=1. The new frame shows ch0 silent.
- ch1 spikes at phase10, then again at phase30 -> only phase10 is captured (intensity ceil(64/9)=8).
- Hold out_ready=0 across the next cycle_start -> overrun pulses once, the old frame drains intact, and the dropped frame's spikes never appear.
- Reset asserted during DIV -> the next clock has out_valid=0 and out_phase=255. The next frame decodes correctly. With SKIP_SILENT_EN and only ch2 hit -> exactly one word, out_chan=2, out_last=1.
